// File: rtl/host_if_arbiter.sv
// +--------------------------------------------------------------------------+
// | Module   : host_if_arbiter                                               |
// | Purpose  : Arbitrates two host command handlers onto one master. A       |
// |            round-robin grant gives one handler ownership for a complete  |
// |            command/response transaction. Ownership ends when the         |
// |            response word count is reached or when a watchdog expires.    |
// | Ports    : clk, rst                 - clock, sync active-high reset      |
// |            i_host_req[1:0]          - per-handler pending-command level  |
// |            i_ih_ready, o_master_ready, i_in_* - handler command side     |
// |            i_oh_ready, o_oh_en, o_out_*       - handler response side    |
// |            o_ih_ready, i_master_ready, o_in_* - master command side      |
// |            i_oh_en, o_oh_ready, i_out_*       - master response side     |
// |            o_owner[1:0] one-hot grant, o_timeout watchdog pulse          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module host_if_arbiter #(
  parameter logic [31:0] TIMEOUT = 32'd100000
) (
  input  logic        clk,
  input  logic        rst,
  // handler side
  input  logic [1:0]  i_host_req,
  input  logic [1:0]  i_ih_ready,
  output logic [1:0]  o_master_ready,
  input  logic [63:0] i_in_command,
  input  logic [63:0] i_in_address,
  input  logic [63:0] i_in_data,
  input  logic [55:0] i_in_data_count,
  input  logic [1:0]  i_oh_ready,
  output logic [1:0]  o_oh_en,
  output logic [31:0] o_out_status,
  output logic [31:0] o_out_address,
  output logic [31:0] o_out_data,
  output logic [27:0] o_out_data_count,
  // master side
  output logic        o_ih_ready,
  input  logic        i_master_ready,
  output logic [31:0] o_in_command,
  output logic [31:0] o_in_address,
  output logic [31:0] o_in_data,
  output logic [27:0] o_in_data_count,
  input  logic        i_oh_en,
  output logic        o_oh_ready,
  input  logic [31:0] i_out_status,
  input  logic [31:0] i_out_address,
  input  logic [31:0] i_out_data,
  input  logic [27:0] i_out_data_count,
  // status
  output logic [1:0]  o_owner,
  output logic        o_timeout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state;
  logic        favor1;      // handler 1 wins the next simultaneous request
  logic [27:0] word_cnt;
  logic [27:0] target;
  logic [31:0] watchdog;

  logic        active;
  logic        sel_oh_ready;
  logic        accept;
  logic [1:0]  grant;
  logic [27:0] first_target;

  // Strobes are forced low while rst is high so an abandoned transaction
  // cannot leak a handshake in the reset cycle.
  assign active = ~rst & (state != S_IDLE);

  assign sel_oh_ready = o_owner[0] ? i_oh_ready[0] :
                        o_owner[1] ? i_oh_ready[1] : 1'b0;

  assign o_oh_ready     = active & sel_oh_ready;
  assign accept         = i_oh_en & o_oh_ready;
  assign o_oh_en        = accept ? o_owner : 2'b00;
  assign o_master_ready = active ? ({2{i_master_ready}} & o_owner) : 2'b00;
  assign o_ih_ready     = active & (|(i_ih_ready & o_owner));

  assign o_out_status     = i_out_status;
  assign o_out_address    = i_out_address;
  assign o_out_data       = i_out_data;
  assign o_out_data_count = i_out_data_count;

  // A zero count still means one response word is transferred.
  assign first_target = (i_out_data_count == 28'd0) ? 28'd1 : i_out_data_count;

  assign grant = (i_host_req == 2'b11) ? (favor1 ? 2'b10 : 2'b01) : i_host_req;

  always_comb begin
    o_in_command    = '0;
    o_in_address    = '0;
    o_in_data       = '0;
    o_in_data_count = '0;
    if (o_owner[0]) begin
      o_in_command    = i_in_command[31:0];
      o_in_address    = i_in_address[31:0];
      o_in_data       = i_in_data[31:0];
      o_in_data_count = i_in_data_count[27:0];
    end else if (o_owner[1]) begin
      o_in_command    = i_in_command[63:32];
      o_in_address    = i_in_address[63:32];
      o_in_data       = i_in_data[63:32];
      o_in_data_count = i_in_data_count[55:28];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      o_owner   <= 2'b00;
      favor1    <= 1'b0;
      word_cnt  <= '0;
      target    <= '0;
      watchdog  <= '0;
      o_timeout <= 1'b0;
    end else begin
      o_timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|i_host_req) begin
            o_owner  <= grant;
            favor1   <= grant[0];
            state    <= S_CMD;
            watchdog <= '0;
            word_cnt <= '0;
            target   <= '0;
          end
        end
        S_CMD, S_RESP: begin
          if (accept) begin
            // An accept always clears the watchdog, so a final word that
            // coincides with expiry completes normally.
            watchdog <= '0;
            if (state == S_CMD) begin
              if (first_target == 28'd1) begin
                state   <= S_IDLE;
                o_owner <= 2'b00;
              end else begin
                target   <= first_target;
                word_cnt <= 28'd1;
                state    <= S_RESP;
              end
            end else if (word_cnt + 28'd1 == target) begin
              state   <= S_IDLE;
              o_owner <= 2'b00;
            end else begin
              word_cnt <= word_cnt + 28'd1;
            end
          end else if (o_ih_ready) begin
            watchdog <= '0;
          end else if (watchdog + 32'd1 == TIMEOUT) begin
            watchdog  <= '0;
            o_timeout <= 1'b1;
            state     <= S_IDLE;
            o_owner   <= 2'b00;
          end else begin
            watchdog <= watchdog + 32'd1;
          end
        end
        default: begin
          state   <= S_IDLE;
          o_owner <= 2'b00;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_host_if_arbiter.sv
`default_nettype none

module tb_host_if_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  i_host_req;
  logic [1:0]  i_ih_ready;
  logic [1:0]  o_master_ready;
  logic [63:0] i_in_command, i_in_address, i_in_data;
  logic [55:0] i_in_data_count;
  logic [1:0]  i_oh_ready;
  logic [1:0]  o_oh_en;
  logic [31:0] o_out_status, o_out_address, o_out_data;
  logic [27:0] o_out_data_count;
  logic        o_ih_ready;
  logic        i_master_ready;
  logic [31:0] o_in_command, o_in_address, o_in_data;
  logic [27:0] o_in_data_count;
  logic        i_oh_en;
  logic        o_oh_ready;
  logic [31:0] i_out_status, i_out_address, i_out_data;
  logic [27:0] i_out_data_count;
  logic [1:0]  o_owner;
  logic        o_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  host_if_arbiter #(.TIMEOUT(32'd16)) dut (
    .clk(clk), .rst(rst),
    .i_host_req(i_host_req), .i_ih_ready(i_ih_ready), .o_master_ready(o_master_ready),
    .i_in_command(i_in_command), .i_in_address(i_in_address), .i_in_data(i_in_data),
    .i_in_data_count(i_in_data_count), .i_oh_ready(i_oh_ready), .o_oh_en(o_oh_en),
    .o_out_status(o_out_status), .o_out_address(o_out_address), .o_out_data(o_out_data),
    .o_out_data_count(o_out_data_count), .o_ih_ready(o_ih_ready),
    .i_master_ready(i_master_ready), .o_in_command(o_in_command),
    .o_in_address(o_in_address), .o_in_data(o_in_data), .o_in_data_count(o_in_data_count),
    .i_oh_en(i_oh_en), .o_oh_ready(o_oh_ready), .i_out_status(i_out_status),
    .i_out_address(i_out_address), .i_out_data(i_out_data),
    .i_out_data_count(i_out_data_count), .o_owner(o_owner), .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_host_req = 0; i_ih_ready = 0; i_in_command = 0; i_in_address = 0;
    i_in_data = 0; i_in_data_count = 0; i_oh_ready = 0; i_master_ready = 0;
    i_oh_en = 0; i_out_status = 0; i_out_address = 0; i_out_data = 0;
    i_out_data_count = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Master streams response words every cycle; reports what each handler saw.
  task automatic drive_response(input logic [27:0] cnt, output int p0, output int p1,
                                output bit released);
    p0 = 0; p1 = 0; released = 0;
    i_oh_ready = 2'b11; i_oh_en = 1'b1; i_out_data_count = cnt;
    for (int c = 0; c < 20 && !released; c++) begin
      #1;
      if (o_oh_en[0]) p0++;
      if (o_oh_en[1]) p1++;
      step();
      if (o_owner == 2'b00) released = 1;
    end
    i_oh_en = 1'b0; i_oh_ready = 2'b00; i_out_data_count = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    i_ih_ready = 2'b11; i_oh_ready = 2'b11; i_oh_en = 1'b1; i_master_ready = 1'b1;
    i_in_command = 64'h1111_2222_3333_4444;
    #1;
    n_checks++;
    if (o_owner !== 2'b00 || o_timeout !== 1'b0) begin
      n_fail++; $display("FAIL reset_state owner=%b timeout=%b expected 00/0", o_owner, o_timeout);
    end
    n_checks++;
    if ({o_ih_ready, o_oh_en, o_master_ready, o_oh_ready} !== 6'b0) begin
      n_fail++; $display("FAIL reset_strobes ih=%b ohen=%b mr=%b ohr=%b expected all 0",
                         o_ih_ready, o_oh_en, o_master_ready, o_oh_ready);
    end
    n_checks++;
    if (o_in_command !== 32'h0) begin
      n_fail++; $display("FAIL reset_in_cmd got=%h expected 0", o_in_command);
    end
    step();
    clear_inputs();
    rst = 1'b0;
    step();
  endtask

  task automatic test_round_robin();
    int p0, p1; bit rel;
    do_reset();
    i_host_req = 2'b11;
    step();
    n_checks++;
    if (o_owner !== 2'b01) begin
      n_fail++; $display("FAIL rr_first_grant owner=%b expected 01", o_owner);
    end
    drive_response(28'd1, p0, p1, rel);
    n_checks++;
    if (!rel || p0 != 1 || p1 != 0) begin
      n_fail++; $display("FAIL rr_release rel=%0d p0=%0d p1=%0d expected 1/1/0", rel, p0, p1);
    end
    step();
    n_checks++;
    if (o_owner !== 2'b10) begin
      n_fail++; $display("FAIL rr_second_grant owner=%b expected 10", o_owner);
    end
    i_host_req = 2'b00;
    drive_response(28'd1, p0, p1, rel);
    n_checks++;
    if (!rel || p0 != 0 || p1 != 1) begin
      n_fail++; $display("FAIL rr_h1_resp rel=%0d p0=%0d p1=%0d expected 1/0/1", rel, p0, p1);
    end
  endtask

  task automatic test_nonowner_strobe();
    int p0, p1; bit rel;
    i_host_req = 2'b10;
    step();
    i_host_req = 2'b00;
    n_checks++;
    if (o_owner !== 2'b10) begin
      n_fail++; $display("FAIL nonowner_grant owner=%b expected 10", o_owner);
    end
    i_in_command = {32'h0000_ABCD, 32'h0000_0001};
    i_ih_ready = 2'b01; i_master_ready = 1'b1;
    #1;
    n_checks++;
    if (o_ih_ready !== 1'b0 || o_master_ready !== 2'b10) begin
      n_fail++; $display("FAIL nonowner_strobe ih=%b mr=%b expected 0/10", o_ih_ready, o_master_ready);
    end
    n_checks++;
    if (o_in_command !== 32'h0000_ABCD) begin
      n_fail++; $display("FAIL nonowner_cmd got=%h expected 0000abcd", o_in_command);
    end
    i_ih_ready = 2'b10;
    #1;
    n_checks++;
    if (o_ih_ready !== 1'b1) begin
      n_fail++; $display("FAIL owner_strobe ih=%b expected 1", o_ih_ready);
    end
    step();
    i_ih_ready = 2'b00; i_master_ready = 1'b0;
    drive_response(28'd1, p0, p1, rel);
    n_checks++;
    if (!rel || p1 != 1 || p0 != 0) begin
      n_fail++; $display("FAIL nonowner_resp rel=%0d p0=%0d p1=%0d expected 1/0/1", rel, p0, p1);
    end
  endtask

  task automatic test_word_count(input logic [27:0] cnt, input int expect_words);
    int p0, p1; bit rel;
    i_host_req = 2'b01;
    step();
    i_host_req = 2'b00;
    n_checks++;
    if (o_owner !== 2'b01) begin
      n_fail++; $display("FAIL count_grant cnt=%0d owner=%b expected 01", cnt, o_owner);
    end
    drive_response(cnt, p0, p1, rel);
    n_checks++;
    if (!rel || p0 != expect_words || p1 != 0) begin
      n_fail++; $display("FAIL count_words cnt=%0d rel=%0d p0=%0d p1=%0d expected 1/%0d/0",
                         cnt, rel, p0, p1, expect_words);
    end
    #1;
    n_checks++;
    if (o_oh_ready !== 1'b0) begin
      n_fail++; $display("FAIL idle_oh_ready got=%b expected 0", o_oh_ready);
    end
  endtask

  task automatic test_timeout();
    int bad = 0;
    i_host_req = 2'b01;
    step();
    i_host_req = 2'b00;   // owner drops its request; ownership must hold
    for (int k = 1; k <= 15; k++) begin
      step();
      if (o_owner !== 2'b01 || o_timeout !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL timeout_early bad_cycles=%0d expected 0", bad);
    end
    step();
    n_checks++;
    if (o_timeout !== 1'b1 || o_owner !== 2'b00) begin
      n_fail++; $display("FAIL timeout_pulse to=%b owner=%b expected 1/00", o_timeout, o_owner);
    end
    step();
    n_checks++;
    if (o_timeout !== 1'b0) begin
      n_fail++; $display("FAIL timeout_width to=%b expected 0", o_timeout);
    end
  endtask

  task automatic test_reset_mid();
    int p0, p1; bit rel;
    i_host_req = 2'b01;
    step();
    i_host_req = 2'b00;
    i_oh_ready = 2'b11; i_oh_en = 1'b1; i_out_data_count = 28'd4;
    step();
    step();
    n_checks++;
    if (o_owner !== 2'b01) begin
      n_fail++; $display("FAIL midrst_owner owner=%b expected 01", o_owner);
    end
    rst = 1'b1; i_ih_ready = 2'b11; i_master_ready = 1'b1;
    #1;
    n_checks++;
    if ({o_ih_ready, o_oh_en, o_master_ready, o_oh_ready} !== 6'b0) begin
      n_fail++; $display("FAIL midrst_strobes ih=%b ohen=%b mr=%b ohr=%b expected all 0",
                         o_ih_ready, o_oh_en, o_master_ready, o_oh_ready);
    end
    step();
    n_checks++;
    if (o_owner !== 2'b00 || o_timeout !== 1'b0) begin
      n_fail++; $display("FAIL midrst_release owner=%b to=%b expected 00/0", o_owner, o_timeout);
    end
    rst = 1'b0;
    clear_inputs();
    i_host_req = 2'b10;
    step();
    i_host_req = 2'b00;
    n_checks++;
    if (o_owner !== 2'b10) begin
      n_fail++; $display("FAIL midrst_regrant owner=%b expected 10", o_owner);
    end
    drive_response(28'd1, p0, p1, rel);
    n_checks++;
    if (!rel || p1 != 1 || p0 != 0) begin
      n_fail++; $display("FAIL midrst_resp rel=%0d p0=%0d p1=%0d expected 1/0/1", rel, p0, p1);
    end
  endtask

  // Transaction-level model: round-robin favourite, target word count.
  task automatic test_random();
    int favored = 0;
    do_reset();
    clear_inputs();
    for (int t = 0; t < 30; t++) begin
      logic [1:0] req, exp_owner, exp_en;
      int w, target, seen, misses;
      logic [27:0] cnt;
      bit done, acc;
      req = 2'($urandom_range(1, 3));
      i_host_req = req;
      w = (req == 2'b11) ? favored : (req == 2'b01 ? 0 : 1);
      favored = 1 - w;
      exp_owner = (w == 0) ? 2'b01 : 2'b10;
      step();
      i_host_req = 2'b00;
      n_checks++;
      if (o_owner !== exp_owner) begin
        n_fail++; $display("FAIL rand_grant t=%0d req=%b owner=%b expected %b", t, req, o_owner, exp_owner);
      end
      for (int c = 0; c < 3; c++) begin
        i_ih_ready = 2'($urandom);
        i_master_ready = 1'($urandom);
        i_in_command = {$urandom, $urandom};
        i_in_data_count = {24'($urandom), $urandom};
        #1;
        n_checks++;
        if (o_ih_ready !== i_ih_ready[w] || o_in_command !== i_in_command[32*w +: 32] ||
            o_in_data_count !== i_in_data_count[28*w +: 28] ||
            o_master_ready !== (i_master_ready ? exp_owner : 2'b00)) begin
          n_fail++; $display("FAIL rand_cmd t=%0d ih=%b cmd=%h cnt=%h mr=%b owner_idx=%0d",
                             t, o_ih_ready, o_in_command, o_in_data_count, o_master_ready, w);
        end
        step();
      end
      i_ih_ready = 2'b00; i_master_ready = 1'b0;
      cnt = 28'($urandom_range(0, 4));
      target = (cnt == 0) ? 1 : int'(cnt);
      seen = 0; misses = 0; done = 0;
      for (int c = 0; c < 60 && !done; c++) begin
        i_oh_ready = 2'($urandom);
        i_oh_en = 1'($urandom);
        if (misses >= 3) begin
          i_oh_ready[w] = 1'b1; i_oh_en = 1'b1;
        end
        i_out_data_count = (seen == 0) ? cnt : 28'($urandom);
        i_out_data = $urandom;
        #1;
        acc = i_oh_en & i_oh_ready[w];
        exp_en = acc ? exp_owner : 2'b00;
        n_checks++;
        if (o_oh_en !== exp_en || o_oh_ready !== i_oh_ready[w] || o_out_data !== i_out_data) begin
          n_fail++; $display("FAIL rand_resp t=%0d ohen=%b exp=%b ohr=%b data=%h", t, o_oh_en,
                             exp_en, o_oh_ready, o_out_data);
        end
        if (acc) begin seen++; misses = 0; end else misses++;
        step();
        if (seen == target) done = 1;
        n_checks++;
        if (o_owner !== (done ? 2'b00 : exp_owner)) begin
          n_fail++; $display("FAIL rand_release t=%0d seen=%0d target=%0d owner=%b", t, seen,
                             target, o_owner);
        end
      end
      n_checks++;
      if (!done) begin
        n_fail++; $display("FAIL rand_bound t=%0d seen=%0d target=%0d", t, seen, target);
      end
      clear_inputs();
    end
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    test_reset();
    test_round_robin();
    test_nonowner_strobe();
    test_word_count(28'd3, 3);
    test_word_count(28'd0, 1);
    test_timeout();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
